// File: rtl/atto_network_interface.sv
// rtl/atto_network_interface.sv - PE-side network interface for the atto router
// Injection FIFO + 2-state launch FSM with diff-pair signalling; ejection FIFO fed by pair transitions.
module atto_network_interface #(
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 2
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        pe_valid_din,
  input  logic [3:0]  pe_dest_x_din,
  input  logic [3:0]  pe_dest_y_din,
  input  logic [39:0] pe_payload_din,
  output logic        pe_ready_dout,
  output logic [47:0] ni_channel_dout,
  output logic [1:0]  ni_diff_pair_dout,
  input  logic        r2pe_ack_din,
  input  logic [39:0] r2ni_channel_din,
  input  logic [1:0]  r2ni_diff_pair_din,
  output logic [39:0] pe_eject_data_dout,
  output logic        pe_eject_valid_dout,
  input  logic        pe_eject_ready_din,
  output logic        pe_eject_overflow_dout,
  output logic        pe_pair_error_dout
);
  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);
  localparam logic [IAW:0] INJ_FULL = (IAW+1)'(INJ_DEPTH);
  localparam logic [EAW:0] EJ_FULL  = (EAW+1)'(EJ_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;
  state_t state_q, state_d;

  logic [47:0]  inj_mem_q [INJ_DEPTH];
  logic [IAW-1:0] inj_wr_q, inj_rd_q;
  logic [IAW:0]   inj_cnt_q;
  logic inj_full, inj_empty, inj_push, inj_pop, launch;
  logic [47:0] chan_q;
  logic [1:0]  pair_q;

  assign inj_full      = (inj_cnt_q == INJ_FULL);
  assign inj_empty     = (inj_cnt_q == '0);
  assign pe_ready_dout = ~rsta & ~inj_full;
  assign inj_push      = pe_valid_din & pe_ready_dout;

  always_ff @(posedge clka) begin
    if (rsta) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (!inj_empty) state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (r2pe_ack_din) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // The head stays in the FIFO while in flight; it is popped only on ack.
  always_comb begin
    launch  = (state_q == S_IDLE) & ~inj_empty;
    inj_pop = (state_q == S_WAIT_ACK) & r2pe_ack_din;
  end

  always_ff @(posedge clka) begin
    if (inj_push) inj_mem_q[inj_wr_q] <= {pe_dest_x_din, pe_dest_y_din, pe_payload_din};
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      inj_wr_q  <= '0;
      inj_rd_q  <= '0;
      inj_cnt_q <= '0;
      chan_q    <= '0;
      pair_q    <= 2'b10;
    end else begin
      if (inj_push) inj_wr_q <= inj_wr_q + 1'b1;
      if (inj_pop)  inj_rd_q <= inj_rd_q + 1'b1;
      case ({inj_push, inj_pop})
        2'b10:   inj_cnt_q <= inj_cnt_q + 1'b1;
        2'b01:   inj_cnt_q <= inj_cnt_q - 1'b1;
        default: inj_cnt_q <= inj_cnt_q;
      endcase
      if (launch) begin
        chan_q <= inj_mem_q[inj_rd_q];
        pair_q <= ~pair_q;
      end
    end
  end

  assign ni_channel_dout   = chan_q;
  assign ni_diff_pair_dout = pair_q;

  logic [39:0]    ej_mem_q [EJ_DEPTH];
  logic [EAW-1:0] ej_wr_q, ej_rd_q;
  logic [EAW:0]   ej_cnt_q;
  logic [1:0]     ej_last_q;
  logic ej_ovf_q, ej_err_q;
  logic ej_legal, ej_new, ej_full, ej_pop, ej_push;

  assign ej_legal = r2ni_diff_pair_din[1] ^ r2ni_diff_pair_din[0];
  assign ej_new   = ej_legal & (r2ni_diff_pair_din != ej_last_q);
  assign ej_full  = (ej_cnt_q == EJ_FULL);
  assign pe_eject_valid_dout = (ej_cnt_q != '0);
  assign ej_pop   = pe_eject_valid_dout & pe_eject_ready_din;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign ej_push  = ej_new & (~ej_full | ej_pop);

  always_ff @(posedge clka) begin
    if (ej_push) ej_mem_q[ej_wr_q] <= r2ni_channel_din;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      ej_wr_q   <= '0;
      ej_rd_q   <= '0;
      ej_cnt_q  <= '0;
      ej_last_q <= 2'b10;
      ej_ovf_q  <= 1'b0;
      ej_err_q  <= 1'b0;
    end else begin
      if (ej_push) ej_wr_q <= ej_wr_q + 1'b1;
      if (ej_pop)  ej_rd_q <= ej_rd_q + 1'b1;
      case ({ej_push, ej_pop})
        2'b10:   ej_cnt_q <= ej_cnt_q + 1'b1;
        2'b01:   ej_cnt_q <= ej_cnt_q - 1'b1;
        default: ej_cnt_q <= ej_cnt_q;
      endcase
      if (ej_legal) ej_last_q <= r2ni_diff_pair_din;
      if (ej_new & ~ej_push) ej_ovf_q <= 1'b1;
      if (!ej_legal) ej_err_q <= 1'b1;
    end
  end

  assign pe_eject_data_dout     = ej_mem_q[ej_rd_q];
  assign pe_eject_overflow_dout = ej_ovf_q;
  assign pe_pair_error_dout     = ej_err_q;
endmodule

// File: tb/tb_atto_network_interface.sv
// tb/tb_atto_network_interface.sv - self-checking bench for atto_network_interface
// Queue-level reference model advanced once per clock; directed plan followed by random traffic.
module tb_atto_network_interface;
  localparam int INJ_DEPTH = 4;
  localparam int EJ_DEPTH  = 2;

  logic        clka = 1'b0;
  logic        rsta;
  logic        pe_valid_din;
  logic [3:0]  pe_dest_x_din, pe_dest_y_din;
  logic [39:0] pe_payload_din;
  logic        pe_ready_dout;
  logic [47:0] ni_channel_dout;
  logic [1:0]  ni_diff_pair_dout;
  logic        r2pe_ack_din;
  logic [39:0] r2ni_channel_din;
  logic [1:0]  r2ni_diff_pair_din;
  logic [39:0] pe_eject_data_dout;
  logic        pe_eject_valid_dout;
  logic        pe_eject_ready_din;
  logic        pe_eject_overflow_dout;
  logic        pe_pair_error_dout;

  atto_network_interface #(.INJ_DEPTH(INJ_DEPTH), .EJ_DEPTH(EJ_DEPTH)) dut (
    .clka(clka), .rsta(rsta),
    .pe_valid_din(pe_valid_din), .pe_dest_x_din(pe_dest_x_din), .pe_dest_y_din(pe_dest_y_din),
    .pe_payload_din(pe_payload_din), .pe_ready_dout(pe_ready_dout),
    .ni_channel_dout(ni_channel_dout), .ni_diff_pair_dout(ni_diff_pair_dout),
    .r2pe_ack_din(r2pe_ack_din), .r2ni_channel_din(r2ni_channel_din),
    .r2ni_diff_pair_din(r2ni_diff_pair_din), .pe_eject_data_dout(pe_eject_data_dout),
    .pe_eject_valid_dout(pe_eject_valid_dout), .pe_eject_ready_din(pe_eject_ready_din),
    .pe_eject_overflow_dout(pe_eject_overflow_dout), .pe_pair_error_dout(pe_pair_error_dout)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad   = 0;

  logic [47:0] iq[$];
  bit          in_flight;
  logic [47:0] m_chan;
  logic [1:0]  m_pair;
  logic [39:0] eq[$];
  logic [1:0]  m_last;
  bit          m_ovf, m_err;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven, then compare.
  task automatic tick();
    bit push, ej_pop, newf, legal;
    int s;
    if (rsta) begin
      iq.delete(); eq.delete();
      in_flight = 0; m_chan = '0; m_pair = 2'b10; m_last = 2'b10; m_ovf = 0; m_err = 0;
    end else begin
      push = pe_valid_din && (iq.size() < INJ_DEPTH);
      if (in_flight) begin
        if (r2pe_ack_din) begin
          void'(iq.pop_front());
          in_flight = 0;
        end
      end else if (iq.size() > 0) begin
        m_chan = iq[0];
        m_pair = ~m_pair;
        in_flight = 1;
      end
      if (push) iq.push_back({pe_dest_x_din, pe_dest_y_din, pe_payload_din});

      s = eq.size();
      ej_pop = (s > 0) && pe_eject_ready_din;
      legal = (r2ni_diff_pair_din == 2'b01) || (r2ni_diff_pair_din == 2'b10);
      newf = legal && (r2ni_diff_pair_din != m_last);
      if (!legal) m_err = 1;
      if (legal) m_last = r2ni_diff_pair_din;
      if (ej_pop) void'(eq.pop_front());
      if (newf) begin
        if (s < EJ_DEPTH || ej_pop) eq.push_back(r2ni_channel_din);
        else m_ovf = 1;
      end
    end
    @(posedge clka);
    #1;
    chk("ready", {47'd0, pe_ready_dout}, {47'd0, (!rsta && iq.size() < INJ_DEPTH)});
    chk("chan", ni_channel_dout, m_chan);
    chk("pair", {46'd0, ni_diff_pair_dout}, {46'd0, m_pair});
    chk("ej_valid", {47'd0, pe_eject_valid_dout}, {47'd0, eq.size() > 0});
    if (eq.size() > 0) chk("ej_data", {8'd0, pe_eject_data_dout}, {8'd0, eq[0]});
    chk("ovf", {47'd0, pe_eject_overflow_dout}, {47'd0, m_ovf});
    chk("err", {47'd0, pe_pair_error_dout}, {47'd0, m_err});
  endtask

  task automatic drive_inj(input logic v, input logic [3:0] x, input logic [3:0] y, input logic [39:0] p);
    pe_valid_din = v; pe_dest_x_din = x; pe_dest_y_din = y; pe_payload_din = p;
  endtask

  initial begin
    rsta = 1; drive_inj(0, 0, 0, 0);
    r2pe_ack_din = 0; r2ni_channel_din = '0; r2ni_diff_pair_din = 2'b10; pe_eject_ready_din = 0;
    #1;
    for (int i = 0; i < 20; i++) tick();
    rsta = 0;
    tick();
    chk("t1_ready", {47'd0, pe_ready_dout}, 48'd1);
    chk("t1_pair", {46'd0, ni_diff_pair_dout}, 48'd2);
    chk("t1_chan", ni_channel_dout, 48'd0);
    chk("t1_ejv", {47'd0, pe_eject_valid_dout}, 48'd0);
    chk("t1_flags", {46'd0, pe_eject_overflow_dout, pe_pair_error_dout}, 48'd0);

    drive_inj(1, 4'd2, 4'd1, 40'h0);
    tick();
    drive_inj(0, 0, 0, 0);
    tick();
    chk("t2_chan", ni_channel_dout, 48'h210000000000);
    chk("t2_pair", {46'd0, ni_diff_pair_dout}, 48'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_hold_chan", ni_channel_dout, 48'h210000000000);
    chk("t2_hold_pair", {46'd0, ni_diff_pair_dout}, 48'd1);
    drive_inj(1, 4'd1, 4'd2, 40'h1111111111);
    tick();
    drive_inj(0, 0, 0, 0);
    r2pe_ack_din = 1;
    tick();
    r2pe_ack_din = 0;
    tick();
    chk("t2_chan2", ni_channel_dout, 48'h121111111111);
    chk("t2_pair2", {46'd0, ni_diff_pair_dout}, 48'd2);
    r2pe_ack_din = 1;
    tick();
    r2pe_ack_din = 0;

    for (int i = 0; i < 4; i++) begin
      drive_inj(1, 4'(i), 4'(i + 8), 40'(64'hA0 + i));
      tick();
    end
    chk("t3_full", {47'd0, pe_ready_dout}, 48'd0);
    drive_inj(1, 4'hF, 4'hE, 40'hDEAD);
    r2pe_ack_din = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      r2pe_ack_din = 0;
      drive_inj(0, 0, 0, 0);
      tick();
      r2pe_ack_din = 1;
      drive_inj(1, 4'(i), 4'(i), 40'(64'hB0 + i));
      tick();
    end
    drive_inj(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      r2pe_ack_din = in_flight;
      tick();
    end
    r2pe_ack_din = 0;
    chk("t3_drained", {47'd0, pe_ready_dout}, 48'd1);

    r2ni_diff_pair_din = 2'b10; r2ni_channel_din = 40'hAAAA; tick();
    r2ni_diff_pair_din = 2'b01; r2ni_channel_din = 40'hBBBB; tick();
    r2ni_diff_pair_din = 2'b01; r2ni_channel_din = 40'hCCCC; tick();
    r2ni_diff_pair_din = 2'b10; r2ni_channel_din = 40'hDDDD; tick();
    chk("t4_head", {8'd0, pe_eject_data_dout}, 48'hBBBB);
    r2ni_diff_pair_din = 2'b01; r2ni_channel_din = 40'hEEEE; tick();
    chk("t4_ovf", {47'd0, pe_eject_overflow_dout}, 48'd1);
    pe_eject_ready_din = 1;
    tick();
    chk("t4_second", {8'd0, pe_eject_data_dout}, 48'hDDDD);
    tick();
    chk("t4_empty", {47'd0, pe_eject_valid_dout}, 48'd0);
    pe_eject_ready_din = 0;

    rsta = 1; r2ni_diff_pair_din = 2'b10; tick();
    rsta = 0;
    r2ni_diff_pair_din = 2'b11; r2ni_channel_din = 40'h1234; tick();
    chk("t5_err", {47'd0, pe_pair_error_dout}, 48'd1);
    chk("t5_nocap", {47'd0, pe_eject_valid_dout}, 48'd0);
    r2ni_diff_pair_din = 2'b01; r2ni_channel_din = 40'h5678; tick();
    chk("t5_cap", {8'd0, pe_eject_data_dout}, 48'h5678);

    for (int i = 0; i < 3; i++) begin
      drive_inj(1, 4'(i + 3), 4'(i + 5), 40'(64'hC0 + i));
      tick();
    end
    drive_inj(0, 0, 0, 0);
    rsta = 1; tick();
    rsta = 0; tick();
    chk("t6_pair", {46'd0, ni_diff_pair_dout}, 48'd2);
    chk("t6_chan", ni_channel_dout, 48'd0);
    r2pe_ack_din = 1; tick();
    r2pe_ack_din = 0; tick(); tick();
    chk("t6_nolaunch", {46'd0, ni_diff_pair_dout}, 48'd2);
    chk("t6_ready", {47'd0, pe_ready_dout}, 48'd1);

    for (int i = 0; i < 400; i++) begin
      drive_inj(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), {8'($urandom), 32'($urandom)});
      r2pe_ack_din = in_flight ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      pe_eject_ready_din = 1'($urandom_range(0, 1));
      r2ni_channel_din = {8'($urandom), 32'($urandom)};
      case ($urandom_range(0, 19))
        0:       r2ni_diff_pair_din = 2'($urandom_range(0, 1) * 3);
        1, 2, 3, 4, 5, 6, 7, 8, 9:
                 r2ni_diff_pair_din = (m_last == 2'b10) ? 2'b01 : 2'b10;
        default: r2ni_diff_pair_din = m_last;
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
